// File: rtl/sys_cntr_tx.sv
// Transmit-side system controller: buffers one read and one ALU response, serialises them LSB
// byte first into the TX FIFO. Define SYS_TX_HDR_EN to prefix each frame with a header byte.
module sys_cntr_tx #(
  parameter int unsigned width = 8
`ifdef SYS_TX_HDR_EN
  ,
  parameter logic [width-1:0] RD_HDR  = 8'hA5,
  parameter logic [width-1:0] ALU_HDR = 8'hC5
`endif
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [width-1:0]   RdData,
  input  logic               RdData_Valid,
  input  logic [2*width-1:0] ALU_OUT,
  input  logic               ALU_Valid,
  input  logic               FIFO_Full,
  output logic [width-1:0]   Wr_Data,
  output logic               Wr_Inc,
  output logic               Busy,
  output logic               Drop_Err
);

  typedef enum logic [2:0] {
    StIdle,
    StRdSend,
    StAluLo,
    StAluHi,
    StRdH,
    StAluH
  } state_t;

`ifdef SYS_TX_HDR_EN
  localparam state_t RdEntry  = StRdH;
  localparam state_t AluEntry = StAluH;
`else
  localparam state_t RdEntry  = StRdSend;
  localparam state_t AluEntry = StAluLo;
`endif

  state_t             state_q, state_d;
  logic               rd_pend_q, rd_pend_d;
  logic               alu_pend_q, alu_pend_d;
  logic [width-1:0]   rd_hold_q, rd_hold_d;
  logic [2*width-1:0] alu_hold_q, alu_hold_d;
  logic               drop_d;
  logic               rd_clear, alu_clear;

  // State register and holding buffers
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      rd_pend_q  <= 1'b0;
      alu_pend_q <= 1'b0;
      rd_hold_q  <= '0;
      alu_hold_q <= '0;
      Drop_Err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rd_pend_d;
      alu_pend_q <= alu_pend_d;
      rd_hold_q  <= rd_hold_d;
      alu_hold_q <= alu_hold_d;
      Drop_Err   <= drop_d;
    end
  end

  // A pending slot that frees up this cycle can accept a new strobe in the same cycle.
  always_comb begin
    rd_clear   = (state_q == StRdSend) && Wr_Inc;
    alu_clear  = (state_q == StAluHi) && Wr_Inc;
    rd_pend_d  = rd_pend_q & ~rd_clear;
    alu_pend_d = alu_pend_q & ~alu_clear;
    rd_hold_d  = rd_hold_q;
    alu_hold_d = alu_hold_q;
    drop_d     = 1'b0;
    if (RdData_Valid) begin
      if (!rd_pend_q || rd_clear) begin
        rd_pend_d = 1'b1;
        rd_hold_d = RdData;
      end else begin
        drop_d = 1'b1;
      end
    end
    if (ALU_Valid) begin
      if (!alu_pend_q || alu_clear) begin
        alu_pend_d = 1'b1;
        alu_hold_d = ALU_OUT;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rd_pend_q)       state_d = RdEntry;
        else if (alu_pend_q) state_d = AluEntry;
      end
`ifdef SYS_TX_HDR_EN
      StRdH:  if (Wr_Inc) state_d = StRdSend;
      StAluH: if (Wr_Inc) state_d = StAluLo;
`endif
      StRdSend: if (Wr_Inc) state_d = alu_pend_q ? AluEntry : StIdle;
      StAluLo:  if (Wr_Inc) state_d = StAluHi;
      StAluHi:  if (Wr_Inc) state_d = rd_pend_q ? RdEntry : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    Wr_Inc  = (state_q != StIdle) && !FIFO_Full;
    Busy    = rd_pend_q | alu_pend_q | (state_q != StIdle);
    Wr_Data = '0;
    unique case (state_q)
`ifdef SYS_TX_HDR_EN
      StRdH:  Wr_Data = RD_HDR;
      StAluH: Wr_Data = ALU_HDR;
`endif
      StRdSend: Wr_Data = rd_hold_q;
      StAluLo:  Wr_Data = alu_hold_q[width-1:0];
      StAluHi:  Wr_Data = alu_hold_q[2*width-1:width];
      default:  Wr_Data = '0;
    endcase
  end

endmodule
